// File: rtl/sid_mixer_tdm.sv
// sid_mixer_tdm: time-multiplexed SID voice mixer with
// filter routing, post-filter sum and master volume.
//
// Ports:
//   clk, iRstN         clock, async active-low reset
//   clkEn              sample strobe, starts one mix frame
//   iVoices            packed signed voice samples
//   iWE/iAddr/iDataW   register write port (0x17 route, 0x18 mode/vol)
//   iLP/iBP/iHP        signed filter outputs
//   oDataR             last written byte
//   oPreFilter/oBypass saturated filter-input and bypass sums
//   oMixValid          pulse when the two sums update
//   oOut/oOutValid     final volume-scaled output and its pulse
//   oOverrun           sticky: strobe arrived during a frame
module sid_mixer_tdm #(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 16,
    parameter int HEADROOM   = 3,
    parameter int MIX_DC     = -7489,
    parameter int MUTE_IDX   = 2
) (
    input  logic                          clk,
    input  logic                          iRstN,
    input  logic                          clkEn,
    input  logic [NUM_VOICES*VOICE_W-1:0] iVoices,
    input  logic                          iWE,
    input  logic [4:0]                    iAddr,
    input  logic [7:0]                    iDataW,
    input  logic [15:0]                   iLP,
    input  logic [15:0]                   iBP,
    input  logic [15:0]                   iHP,
    output logic [7:0]                    oDataR,
    output logic [15:0]                   oPreFilter,
    output logic [15:0]                   oBypass,
    output logic                          oMixValid,
    output logic [15:0]                   oOut,
    output logic                          oOutValid,
    output logic                          oOverrun
);

    localparam int ACC_W = VOICE_W + 4;
    localparam int VW    = NUM_VOICES * VOICE_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_SAT   = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_VOL   = 3'd4;

    localparam logic [2:0] LAST_IDX = 3'(NUM_VOICES - 1);
    localparam logic [2:0] MUTE_I   = 3'(MUTE_IDX);

    logic [2:0]            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_VOICES-1:0] route_q, route_d;
    logic [2:0]            mode_q, mode_d;
    logic [3:0]            vol_q, vol_d;
    logic                  mute_q, mute_d;
    logic [7:0]            last_q, last_d;

    // Per-frame snapshot so register writes only hit the next frame
    logic [VW-1:0]         s_voices_q, s_voices_d;
    logic [NUM_VOICES-1:0] s_route_q, s_route_d;
    logic [2:0]            s_mode_q, s_mode_d;
    logic [3:0]            s_vol_q, s_vol_d;
    logic                  s_mute_q, s_mute_d;

    logic signed [ACC_W-1:0] pre_acc_q, pre_acc_d;
    logic signed [ACC_W-1:0] byp_acc_q, byp_acc_d;

    logic [15:0] pre_out_q, pre_out_d;
    logic [15:0] byp_out_q, byp_out_d;
    logic [15:0] post_q, post_d;
    logic [15:0] out_q, out_d;
    logic        mix_valid_q, mix_valid_d;
    logic        out_valid_q, out_valid_d;
    logic        overrun_q, overrun_d;

    logic [VOICE_W-1:0]      voice_sel;
    logic                    route_bit;
    logic signed [ACC_W-1:0] voice_shr;
    logic signed [18:0]      post_sum;
    logic signed [20:0]      vol_prod;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7fff;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Voice and route bit for the current accumulate slot
    always_comb begin
        voice_sel = '0;
        route_bit = 1'b0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (idx_q == 3'(k)) begin
                voice_sel = s_voices_q[k*VOICE_W +: VOICE_W];
                route_bit = s_route_q[k];
            end
        end
        voice_shr = ACC_W'(signed'(voice_sel)) >>> HEADROOM;
    end

    always_comb begin
        post_sum = 19'(signed'(byp_out_q)) + 19'(MIX_DC);
        if (s_mode_q[0]) post_sum = post_sum + 19'(signed'(iLP));
        if (s_mode_q[1]) post_sum = post_sum + 19'(signed'(iBP));
        if (s_mode_q[2]) post_sum = post_sum + 19'(signed'(iHP));
        vol_prod = 21'(signed'(post_q))
                 * 21'(signed'({1'b0, s_vol_q}));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        route_d     = route_q;
        mode_d      = mode_q;
        vol_d       = vol_q;
        mute_d      = mute_q;
        last_d      = last_q;
        s_voices_d  = s_voices_q;
        s_route_d   = s_route_q;
        s_mode_d    = s_mode_q;
        s_vol_d     = s_vol_q;
        s_mute_d    = s_mute_q;
        pre_acc_d   = pre_acc_q;
        byp_acc_d   = byp_acc_q;
        pre_out_d   = pre_out_q;
        byp_out_d   = byp_out_q;
        post_d      = post_q;
        out_d       = out_q;
        mix_valid_d = 1'b0;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (iWE) begin
            last_d = iDataW;
            if (iAddr == 5'h17) begin
                route_d = iDataW[NUM_VOICES-1:0];
            end
            if (iAddr == 5'h18) begin
                mute_d = iDataW[7];
                mode_d = iDataW[6:4];
                vol_d  = iDataW[3:0];
            end
        end

        if (clkEn && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clkEn) begin
                    s_voices_d = iVoices;
                    s_route_d  = route_q;
                    s_mode_d   = mode_q;
                    s_vol_d    = vol_q;
                    s_mute_d   = mute_q;
                    pre_acc_d  = '0;
                    byp_acc_d  = '0;
                    idx_d      = 3'd0;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (route_bit) begin
                    pre_acc_d = pre_acc_q + voice_shr;
                end else if (!(s_mute_q && (idx_q == MUTE_I))) begin
                    byp_acc_d = byp_acc_q + voice_shr;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_SAT: begin
                pre_out_d   = sat16(32'(pre_acc_q));
                byp_out_d   = sat16(32'(byp_acc_q));
                mix_valid_d = 1'b1;
                state_d     = ST_POST;
            end
            ST_POST: begin
                post_d  = sat16(32'(post_sum));
                state_d = ST_VOL;
            end
            ST_VOL: begin
                // floor division by 16 via arithmetic shift
                out_d       = 16'(vol_prod >>> 4);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            route_q     <= '0;
            mode_q      <= '0;
            vol_q       <= 4'hF;
            mute_q      <= 1'b0;
            last_q      <= '0;
            s_voices_q  <= '0;
            s_route_q   <= '0;
            s_mode_q    <= '0;
            s_vol_q     <= '0;
            s_mute_q    <= 1'b0;
            pre_acc_q   <= '0;
            byp_acc_q   <= '0;
            pre_out_q   <= '0;
            byp_out_q   <= '0;
            post_q      <= '0;
            out_q       <= '0;
            mix_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            route_q     <= route_d;
            mode_q      <= mode_d;
            vol_q       <= vol_d;
            mute_q      <= mute_d;
            last_q      <= last_d;
            s_voices_q  <= s_voices_d;
            s_route_q   <= s_route_d;
            s_mode_q    <= s_mode_d;
            s_vol_q     <= s_vol_d;
            s_mute_q    <= s_mute_d;
            pre_acc_q   <= pre_acc_d;
            byp_acc_q   <= byp_acc_d;
            pre_out_q   <= pre_out_d;
            byp_out_q   <= byp_out_d;
            post_q      <= post_d;
            out_q       <= out_d;
            mix_valid_q <= mix_valid_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign oDataR     = last_q;
    assign oPreFilter = pre_out_q;
    assign oBypass    = byp_out_q;
    assign oMixValid  = mix_valid_q;
    assign oOut       = out_q;
    assign oOutValid  = out_valid_q;
    assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_sid_mixer_tdm.sv
// tb_sid_mixer_tdm: checks three mixer configurations against
// a frame-level arithmetic model plus literal expectations.
module tb_sid_mixer_tdm;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            iRstN  = 1'b0;
    logic            clkEn  = 1'b0;
    logic [N*16-1:0] iVoices = '0;
    logic            iWE    = 1'b0;
    logic [4:0]      iAddr  = '0;
    logic [7:0]      iDataW = '0;
    logic [15:0]     iLP    = '0;
    logic [15:0]     iBP    = '0;
    logic [15:0]     iHP    = '0;

    logic [2:0][7:0]  o_dr;
    logic [2:0][15:0] o_pre;
    logic [2:0][15:0] o_byp;
    logic [2:0][15:0] o_out;
    logic [2:0]       o_mv;
    logic [2:0]       o_ov;
    logic [2:0]       o_orun;

    sid_mixer_tdm u_a (
        .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
        .iVoices(iVoices), .iWE(iWE), .iAddr(iAddr),
        .iDataW(iDataW), .iLP(iLP), .iBP(iBP), .iHP(iHP),
        .oDataR(o_dr[0]), .oPreFilter(o_pre[0]),
        .oBypass(o_byp[0]), .oMixValid(o_mv[0]),
        .oOut(o_out[0]), .oOutValid(o_ov[0]),
        .oOverrun(o_orun[0])
    );

    sid_mixer_tdm #(.MIX_DC(0)) u_b (
        .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
        .iVoices(iVoices), .iWE(iWE), .iAddr(iAddr),
        .iDataW(iDataW), .iLP(iLP), .iBP(iBP), .iHP(iHP),
        .oDataR(o_dr[1]), .oPreFilter(o_pre[1]),
        .oBypass(o_byp[1]), .oMixValid(o_mv[1]),
        .oOut(o_out[1]), .oOutValid(o_ov[1]),
        .oOverrun(o_orun[1])
    );

    sid_mixer_tdm #(.HEADROOM(0), .MIX_DC(0)) u_c (
        .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
        .iVoices(iVoices), .iWE(iWE), .iAddr(iAddr),
        .iDataW(iDataW), .iLP(iLP), .iBP(iBP), .iHP(iHP),
        .oDataR(o_dr[2]), .oPreFilter(o_pre[2]),
        .oBypass(o_byp[2]), .oMixValid(o_mv[2]),
        .oOut(o_out[2]), .oOutValid(o_ov[2]),
        .oOverrun(o_orun[2])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int mv_cnt = 0;

    function automatic int hr_of(int d);
        return (d == 2) ? 0 : 3;
    endfunction

    function automatic int dc_of(int d);
        return (d == 0) ? -7489 : 0;
    endfunction

    function automatic int sat(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int s16(logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s: got %0d expected %0d",
                         nm, act, exp);
        end
    endtask

    // Frame-level model: a frame occupies N+4 edges; sums are
    // published N+1 edges after the strobe, output N+3 edges after.
    bit m_active = 0;
    int m_ph     = 0;
    int m_route  = 0;
    int m_mode   = 0;
    int m_vol    = 15;
    int m_mute   = 0;
    int m_last   = 0;
    int s_mode   = 0;
    int s_vol    = 0;
    int p_pre[3];
    int p_byp[3];
    int e_pre[3];
    int e_byp[3];
    int e_out[3];
    bit e_mv   = 0;
    bit e_ov   = 0;
    bit e_orun = 0;

    task automatic m_reset();
        m_active = 0;
        m_ph     = 0;
        m_route  = 0;
        m_mode   = 0;
        m_vol    = 15;
        m_mute   = 0;
        m_last   = 0;
        e_mv     = 0;
        e_ov     = 0;
        e_orun   = 0;
        for (int d = 0; d < 3; d++) begin
            e_pre[d] = 0;
            e_byp[d] = 0;
            e_out[d] = 0;
        end
    endtask

    task automatic m_step();
        int sh;
        int s;
        e_mv = 0;
        e_ov = 0;
        if (m_active) begin
            m_ph++;
            if (clkEn) e_orun = 1;
            if (m_ph == N + 1) begin
                for (int d = 0; d < 3; d++) begin
                    e_pre[d] = p_pre[d];
                    e_byp[d] = p_byp[d];
                end
                e_mv = 1;
            end
            if (m_ph == N + 3) begin
                for (int d = 0; d < 3; d++) begin
                    s = e_byp[d] + dc_of(d);
                    if (s_mode[0]) s += s16(iLP);
                    if (s_mode[1]) s += s16(iBP);
                    if (s_mode[2]) s += s16(iHP);
                    e_out[d] = (sat(s) * s_vol) >>> 4;
                end
                e_ov = 1;
                m_active = 0;
            end
        end else if (clkEn) begin
            m_active = 1;
            m_ph     = 0;
            s_mode   = m_mode;
            s_vol    = m_vol;
            for (int d = 0; d < 3; d++) begin
                p_pre[d] = 0;
                p_byp[d] = 0;
                for (int k = 0; k < N; k++) begin
                    sh = s16(iVoices[k*16 +: 16]) >>> hr_of(d);
                    if (((m_route >> k) & 1) == 1)
                        p_pre[d] += sh;
                    else if (!(k == 2 && m_mute == 1))
                        p_byp[d] += sh;
                end
                p_pre[d] = sat(p_pre[d]);
                p_byp[d] = sat(p_byp[d]);
            end
        end
        if (iWE) begin
            m_last = int'(iDataW);
            if (iAddr == 5'h17) m_route = int'(iDataW) & 7;
            if (iAddr == 5'h18) begin
                m_mute = int'(iDataW[7]);
                m_mode = (int'(iDataW) >> 4) & 7;
                m_vol  = int'(iDataW) & 15;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge iRstN);
            if (!iRstN) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (o_mv[0]) mv_cnt++;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_pre", d), s16(o_pre[d]), e_pre[d]);
                chk($sformatf("d%0d_byp", d), s16(o_byp[d]), e_byp[d]);
                chk($sformatf("d%0d_out", d), s16(o_out[d]), e_out[d]);
                chk($sformatf("d%0d_mv", d), int'(o_mv[d]), int'(e_mv));
                chk($sformatf("d%0d_ov", d), int'(o_ov[d]), int'(e_ov));
                chk($sformatf("d%0d_orun", d), int'(o_orun[d]),
                    int'(e_orun));
                chk($sformatf("d%0d_dr", d), int'(o_dr[d]), m_last);
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] dat);
        @(negedge clk);
        iWE    = 1'b1;
        iAddr  = a;
        iDataW = dat;
        @(negedge clk);
        iWE    = 1'b0;
    endtask

    task automatic set_v(input int v0, input int v1, input int v2);
        iVoices = {16'(v2), 16'(v1), 16'(v0)};
    endtask

    task automatic wait_valid(output int lmv, output int lov);
        lmv = -1;
        lov = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #3;
            if (o_mv[0] && lmv < 0) lmv = i;
            if (o_ov[0]) begin
                lov = i;
                break;
            end
        end
    endtask

    task automatic frame(output int lmv, output int lov);
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        wait_valid(lmv, lov);
    endtask

    int lmv;
    int lov;
    int m0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out", s16(o_out[0]), 0);
        chk("rst_byp", s16(o_byp[0]), 0);
        chk("rst_dr", int'(o_dr[0]), 0);
        chk("rst_orun", int'(o_orun[0]), 0);
        iRstN = 1'b1;

        // default registers, single unrouted voice
        set_v(8000, 0, 0);
        frame(lmv, lov);
        chk("lat_mv", lmv, 4);
        chk("lat_ov", lov, 6);
        chk("a_byp", s16(o_byp[0]), 1000);
        chk("a_pre", s16(o_pre[0]), 0);
        chk("a_out", s16(o_out[0]), -6084);
        chk("b_byp", s16(o_byp[1]), 1000);
        chk("b_out", s16(o_out[1]), 937);
        chk("c_out", s16(o_out[2]), 7500);

        // route voice 0 to filter, LP enabled
        wr(5'h17, 8'h01);
        wr(5'h18, 8'h1F);
        iLP = 16'd500;
        frame(lmv, lov);
        chk("route_pre", s16(o_pre[0]), 1000);
        chk("route_byp", s16(o_byp[0]), 0);
        chk("lp_out", s16(o_out[0]), -6553);
        chk("lp_out_c", s16(o_out[2]), 468);
        chk("dr_1f", int'(o_dr[0]), 31);
        iLP = 16'd0;

        // saturation of the bypass sum
        wr(5'h17, 8'h00);
        wr(5'h18, 8'h0F);
        set_v(30000, 30000, 0);
        frame(lmv, lov);
        chk("sat_hi", s16(o_byp[2]), 32767);
        chk("sat_hi_out", s16(o_out[2]), 30719);
        chk("nosat_a", s16(o_byp[0]), 7500);
        set_v(-30000, -30000, 0);
        frame(lmv, lov);
        chk("sat_lo", s16(o_byp[2]), -32768);
        chk("sat_lo_out", s16(o_out[2]), -30720);

        // mute of voice 2 in bypass only
        wr(5'h18, 8'h8F);
        set_v(0, 0, 8000);
        frame(lmv, lov);
        chk("mute_byp", s16(o_byp[0]), 0);
        wr(5'h17, 8'h04);
        frame(lmv, lov);
        chk("mute_pre", s16(o_pre[0]), 1000);

        // write during a frame lands in the next one
        set_v(8000, 0, 0);
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn  = 1'b0;
        iWE    = 1'b1;
        iAddr  = 5'h17;
        iDataW = 8'h01;
        @(negedge clk);
        iWE = 1'b0;
        wait_valid(lmv, lov);
        chk("snap_byp", s16(o_byp[0]), 1000);
        chk("snap_pre", s16(o_pre[0]), 0);
        frame(lmv, lov);
        chk("next_pre", s16(o_pre[0]), 1000);

        // strobe one cycle after the final stage: new frame
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        repeat (6) @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        chk("b2b_orun", int'(o_orun[0]), 0);
        wait_valid(lmv, lov);
        chk("b2b_lat", lmv, 4);

        // strobe during the final stage: overrun, no frame
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        repeat (5) @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        chk("vol_orun", int'(o_orun[0]), 1);
        m0 = mv_cnt;
        repeat (10) @(negedge clk);
        chk("vol_noframe", mv_cnt - m0, 0);

        // strobes at cycles 0 and 2: one frame only
        m0 = mv_cnt;
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        repeat (12) @(negedge clk);
        chk("one_frame", mv_cnt - m0, 1);
        chk("orun_set", int'(o_orun[0]), 1);

        // reset two cycles into a frame
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        repeat (2) @(negedge clk);
        iRstN = 1'b0;
        m0 = mv_cnt;
        repeat (4) @(negedge clk);
        chk("rst_nomv", mv_cnt - m0, 0);
        chk("rst2_pre", s16(o_pre[0]), 0);
        chk("rst2_byp", s16(o_byp[0]), 0);
        chk("rst2_out", s16(o_out[0]), 0);
        chk("rst2_orun", int'(o_orun[0]), 0);
        chk("rst2_dr", int'(o_dr[0]), 0);
        iRstN = 1'b1;
        set_v(8000, 0, 0);
        frame(lmv, lov);
        chk("clean_lat", lmv, 4);
        chk("clean_byp", s16(o_byp[0]), 1000);
        chk("clean_out", s16(o_out[0]), -6084);
        chk("clean_orun", int'(o_orun[0]), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sid_mixer_tdm.md
SID_MIXER_TDM -- requirements
Module: sid_mixer_tdm

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, voice count (1..8).
REQ-002 SHALL have parameter VOICE_W, default 16, signed width of each amplified voice sample.
REQ-003 SHALL have parameter HEADROOM, default 3, arithmetic right shift applied to each voice before summing.
REQ-004 SHALL have parameter MIX_DC, default -7489, signed constant added in the post-filter sum.
REQ-005 SHALL have parameter MUTE_IDX, default 2, voice index muted from bypass by register 0x18 bit 7.
REQ-006 clk  in  1  master clock; one clock; all state on rising edge.
REQ-007 iRstN  in  1  reset, asynchronous, active-low.
REQ-008 clkEn  in  1  sample strobe (1 MHz enable); starts one mix frame.
REQ-009 iVoices  in  NUM_VOICES*VOICE_W  signed voice samples, voice k at bits [k*VOICE_W +: VOICE_W].
REQ-010 iWE / iAddr / iDataW  in  1/5/8  register write strobe, address, data.
REQ-011 iLP / iBP / iHP  in  16 each  signed filter outputs.
REQ-012 oDataR  out  8  read data; equals last written byte, combinational.
REQ-013 oPreFilter / oBypass  out  16 each  signed saturated filter-input sum and bypass sum.
REQ-014 oMixValid  out  1  one-cycle pulse when oPreFilter/oBypass update.
REQ-015 oOut  out  16  signed final output after master volume.
REQ-016 oOutValid  out  1  one-cycle pulse when oOut updates.
REQ-017 oOverrun  out  1  sticky flag, clkEn arrived while a frame was in progress.

Function
REQ-018 Register 0x17 write SHALL load route mask = iDataW[NUM_VOICES-1:0]; bit k=1 routes voice k to the filter, else to bypass.
REQ-019 Register 0x18 write SHALL load mode = iDataW[6:4] (LP, BP, HP enables), volume = iDataW[3:0], mute3 = iDataW[7].
REQ-020 Every write SHALL update the last-write byte regardless of address.
REQ-021 FSM states SHALL be IDLE, ACCUM, SAT, POST, VOL.
REQ-022 IDLE + clkEn: snapshot iVoices, route, mode, volume, mute3; clear both accumulators; idx=0; go to ACCUM.
REQ-023 ACCUM, one voice per cycle: add (voice[idx] >>> HEADROOM) to the pre accumulator if routed, else to the bypass accumulator unless idx==MUTE_IDX and mute3=1; go to SAT after idx==NUM_VOICES-1.
REQ-024 Accumulators SHALL be VOICE_W+4 bits signed and SHALL never wrap.
REQ-025 SAT: saturate both sums to [-32768, 32767]; register oPreFilter/oBypass; pulse oMixValid; go to POST.
REQ-026 POST: sum = oBypass + enabled iLP/iBP/iHP + MIX_DC in 19-bit signed; saturate to 16 bits; go to VOL.
REQ-027 VOL: oOut = floor((sat * volume) / 16) (arithmetic shift); pulse oOutValid; go to IDLE.
REQ-028 Latency from the clkEn cycle SHALL be NUM_VOICES+1 cycles to oMixValid and NUM_VOICES+3 cycles to oOutValid.
REQ-029 clkEn outside IDLE SHALL be ignored and SHALL set oOverrun; oOverrun clears only on reset.
REQ-030 Register writes during a frame SHALL affect only the next frame; the frame uses its snapshot.
REQ-031 clkEn in the same cycle as the VOL state SHALL count as overrun; clkEn on the cycle after VOL SHALL start a frame.

Reset
REQ-032 While iRstN=0: FSM=IDLE; route=0; mode=0; volume=0xF; mute3=0; last-write=0; oPreFilter, oBypass, oOut=0; valids=0; oOverrun=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no valid pulse; the first clkEn after release SHALL start a clean frame.

Verification
REQ-034 Defaults, MIX_DC=0, voice0=8000, others 0, route=0, mode=0, vol=15 -> oBypass=1000 at cycle 4, oOut=937 at cycle 6.
REQ-035 Write 0x17=0x01, voice0=8000 -> oPreFilter=1000, oBypass=0; write 0x18=0x1F, iLP=500 -> oOut=floor((500-7489)*15/16)=-6553.
REQ-036 HEADROOM=0, voices 30000, 30000, 0, route=0 -> oBypass=32767; voices -30000, -30000 -> -32768.
REQ-037 Write 0x18=0x8F, voice2=8000 unrouted -> oBypass=0; same with 0x17=0x04 -> oPreFilter=1000.
REQ-038 clkEn at cycles 0 and 2 -> a single frame completes, oOverrun=1; reset asserted at cycle 2 of a new frame -> no oMixValid, all outputs 0.
